// File: rtl/multdiv_stall_ctrl.sv
// Sequences the shared multicycle mult/div unit against the 5-stage pipeline and
// inserts the single-cycle load-use stall that the bypass network cannot cover.
module multdiv_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mult_DX,
  input  logic       div_DX,
  input  logic       flush_DX,
  input  logic       load_DX,
  input  logic [4:0] rd_DX,
  input  logic [4:0] rs_FD,
  input  logic [4:0] rt_FD,
  input  logic       uses_rs_FD,
  input  logic       uses_rt_FD,
  input  logic       store_FD,
  input  logic       md_rdy,
  input  logic       md_exc,
  output logic       md_ctrl_mult,
  output logic       md_ctrl_div,
  output logic       pc_we,
  output logic       fd_we,
  output logic       dx_bubble,
  output logic       dx_we,
  output logic       xm_bubble,
  output logic       md_result_we,
  output logic       md_ovf,
  output logic       md_busy
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             launch, luse, timeout;

  assign launch  = (mult_DX | div_DX) & ~flush_DX;
  assign luse    = load_DX & ~flush_DX & (rd_DX != 5'd0) &
                   ((uses_rs_FD & (rs_FD == rd_DX)) |
                    (uses_rt_FD & ~store_FD & (rt_FD == rd_DX)));
  assign timeout = (count_q == CntLast);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    pc_we        = 1'b1;
    fd_we        = 1'b1;
    dx_bubble    = 1'b0;
    dx_we        = 1'b1;
    xm_bubble    = 1'b0;
    md_result_we = 1'b0;
    md_ovf       = 1'b0;
    md_busy      = 1'b0;
    // Under reset every qualifier is masked so the pipeline sees plain IDLE values.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            md_ctrl_mult = mult_DX;
            md_ctrl_div  = div_DX & ~mult_DX;
            pc_we        = 1'b0;
            fd_we        = 1'b0;
            dx_we        = 1'b0;
            xm_bubble    = 1'b1;
            state_d      = StBusy;
            count_d      = '0;
          end else if (luse) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_bubble = 1'b1;
          end
        end
        StBusy: begin
          md_busy = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
          if (md_rdy || timeout) begin
            md_result_we = 1'b1;
            md_ovf       = md_rdy ? md_exc : 1'b1;
            state_d      = StIdle;
          end else begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            xm_bubble = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed test-plan steps followed by random traffic, checked against a
// cycle-count reference model of the mult/div sequencing rules.
module tb_multdiv_stall_ctrl;

  localparam int MdTimeout = 40;

  logic clock = 1'b0;
  logic reset;
  logic mult_DX, div_DX, flush_DX, load_DX;
  logic [4:0] rd_DX, rs_FD, rt_FD;
  logic uses_rs_FD, uses_rt_FD, store_FD, md_rdy, md_exc;
  logic md_ctrl_mult, md_ctrl_div, pc_we, fd_we, dx_bubble, dx_we;
  logic xm_bubble, md_result_we, md_ovf, md_busy;

  int checks = 0;
  int errors = 0;

  // Model: whether an operation is outstanding and how many BUSY cycles have elapsed.
  bit m_busy = 1'b0;
  int m_elapsed = 0;

  always #5 clock = ~clock;

  multdiv_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .mult_DX(mult_DX), .div_DX(div_DX),
    .flush_DX(flush_DX), .load_DX(load_DX), .rd_DX(rd_DX), .rs_FD(rs_FD),
    .rt_FD(rt_FD), .uses_rs_FD(uses_rs_FD), .uses_rt_FD(uses_rt_FD),
    .store_FD(store_FD), .md_rdy(md_rdy), .md_exc(md_exc),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .pc_we(pc_we),
    .fd_we(fd_we), .dx_bubble(dx_bubble), .dx_we(dx_we), .xm_bubble(xm_bubble),
    .md_result_we(md_result_we), .md_ovf(md_ovf), .md_busy(md_busy)
  );

  // Bit order: mult div pc fd dxb dxwe xmb rwe ovf busy
  function automatic logic [9:0] expected();
    logic [9:0] e;
    bit launch, luse;
    e = 10'b0011010000;
    launch = (mult_DX || div_DX) && !flush_DX;
    luse = load_DX && !flush_DX && rd_DX != 0 &&
           ((uses_rs_FD && rs_FD == rd_DX) || (uses_rt_FD && !store_FD && rt_FD == rd_DX));
    if (!reset) begin
      if (!m_busy) begin
        if (launch) e = {mult_DX, div_DX && !mult_DX, 8'b00001000};
        else if (luse) e = 10'b0000110000;
      end else if (md_rdy || m_elapsed >= MdTimeout - 1) begin
        e = {8'b00110101, md_rdy ? md_exc : 1'b1, 1'b1};
      end else begin
        e = 10'b0000001001;
      end
    end
    return e;
  endfunction

  function automatic logic [9:0] observed();
    return {md_ctrl_mult, md_ctrl_div, pc_we, fd_we, dx_bubble, dx_we, xm_bubble,
            md_result_we, md_ovf, md_busy};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string tag);
    #1;
    chk(tag, observed(), expected());
  endtask

  task automatic tick();
    bit done;
    @(posedge clock);
    done = m_busy && (md_rdy || m_elapsed >= MdTimeout - 1);
    if (reset) begin
      m_busy = 1'b0;
      m_elapsed = 0;
    end else if (!m_busy) begin
      if ((mult_DX || div_DX) && !flush_DX) begin
        m_busy = 1'b1;
        m_elapsed = 0;
      end
    end else if (done) begin
      m_busy = 1'b0;
    end else begin
      m_elapsed++;
    end
    @(negedge clock);
  endtask

  task automatic clear();
    {mult_DX, div_DX, flush_DX, load_DX, uses_rs_FD, uses_rt_FD, store_FD} = '0;
    {md_rdy, md_exc} = '0;
    rd_DX = 0; rs_FD = 0; rt_FD = 0;
  endtask

  initial begin
    int busy_cnt;
    reset = 1'b1;
    clear();
    @(negedge clock);
    cmp("reset_outputs");
    chk("reset_idle_values", observed(), 10'b0011010000);
    tick();
    reset = 1'b0;
    cmp("post_reset_idle");

    // MULT, md_rdy in BUSY cycle 32
    mult_DX = 1'b1;
    cmp("mult_launch");
    chk("mult_launch_fields", observed(), 10'b1000001000);
    tick();
    busy_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      md_rdy = (i == 32);
      cmp("mult_busy");
      if (md_busy === 1'b1) busy_cnt++;
      if (i == 1) chk("mult_pulse_once", {9'b0, md_ctrl_mult}, 10'b0);
      if (i == 32) chk("mult_complete", {md_result_we, md_ovf, pc_we}, 3'b101);
      tick();
    end
    clear();
    cmp("mult_back_idle");
    chk("mult_busy_len", 10'(busy_cnt), 10'd32);
    chk("mult_idle_busy", {9'b0, md_busy}, 10'b0);

    // DIV with exception
    div_DX = 1'b1;
    cmp("div_launch");
    chk("div_pulse", {md_ctrl_mult, md_ctrl_div}, 2'b01);
    tick();
    md_rdy = 1'b1;
    md_exc = 1'b1;
    cmp("div_exc");
    chk("div_exc_fields", {md_result_we, md_ovf}, 2'b11);
    tick();
    clear();

    // Timeout: md_rdy never rises
    mult_DX = 1'b1;
    cmp("to_launch");
    tick();
    for (int i = 1; i <= MdTimeout; i++) begin
      cmp("to_busy");
      if (i == MdTimeout) chk("to_forced", {md_result_we, md_ovf, pc_we}, 3'b111);
      else if (i == MdTimeout - 1) chk("to_not_early", {9'b0, md_result_we}, 10'b0);
      tick();
    end
    clear();
    cmp("to_back_idle");
    chk("to_idle_busy", {9'b0, md_busy}, 10'b0);

    // Load-use hazards with LW r5 in D/X
    load_DX = 1'b1; rd_DX = 5'd5; rs_FD = 5'd5; uses_rs_FD = 1'b1;
    cmp("luse_rs");
    chk("luse_rs_stall", {pc_we, fd_we, dx_bubble, dx_we}, 4'b0011);
    tick();
    uses_rs_FD = 1'b0; rs_FD = 5'd1; uses_rt_FD = 1'b1; rt_FD = 5'd5; store_FD = 1'b1;
    cmp("luse_sw");
    chk("luse_sw_nostall", {pc_we, dx_bubble}, 2'b10);
    tick();
    rd_DX = 5'd0; rs_FD = 5'd0; uses_rs_FD = 1'b1; store_FD = 1'b0; rt_FD = 5'd0;
    cmp("luse_r0");
    chk("luse_r0_nostall", {pc_we, dx_bubble}, 2'b10);
    tick();
    clear();

    // Flushed MULT
    mult_DX = 1'b1; flush_DX = 1'b1;
    cmp("flush_mult");
    chk("flush_no_pulse", {md_ctrl_mult, pc_we}, 2'b01);
    tick();
    clear();
    cmp("flush_idle");
    chk("flush_stays_idle", {9'b0, md_busy}, 10'b0);

    // Reset in BUSY cycle 10, then a normal relaunch
    mult_DX = 1'b1;
    cmp("rst_launch");
    tick();
    for (int i = 1; i <= 9; i++) begin
      cmp("rst_busy");
      tick();
    end
    reset = 1'b1;
    cmp("rst_mid_busy");
    chk("rst_no_strobe", {md_result_we, md_busy}, 2'b00);
    tick();
    reset = 1'b0;
    cmp("rst_relaunch");
    chk("rst_relaunch_fields", {md_ctrl_mult, md_busy}, 2'b10);
    tick();
    md_rdy = 1'b1;
    cmp("rst_relaunch_done");
    chk("rst_relaunch_complete", {9'b0, md_result_we}, 10'b1);
    tick();
    clear();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      mult_DX = ($urandom_range(0, 9) == 0);
      div_DX = ($urandom_range(0, 9) == 0);
      flush_DX = ($urandom_range(0, 3) == 0);
      load_DX = ($urandom_range(0, 2) == 0);
      rd_DX = 5'($urandom_range(0, 3));
      rs_FD = 5'($urandom_range(0, 3));
      rt_FD = 5'($urandom_range(0, 3));
      uses_rs_FD = 1'($urandom);
      uses_rt_FD = 1'($urandom);
      store_FD = 1'($urandom);
      md_rdy = ($urandom_range(0, 59) == 0);
      md_exc = 1'($urandom);
      cmp("random");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
